// File: rtl/ctc_pkg.sv
// Shared types for the commit trace checker: expected-record layout, FSM states, mismatch_field bit indices.
// The PC field only exists when CTC_PC_CHECK_EN is defined.
package ctc_pkg;

    typedef struct packed {
`ifdef CTC_PC_CHECK_EN
        logic [15:0] pc;
`endif
        logic        regwr;
        logic [2:0]  wreg;
        logic [15:0] wdata;
        logic        memwr;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic        halt;
    } ctc_rec_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DONE = 2'd1,
        FAIL = 2'd2
    } ctc_state_e;

    localparam int MF_PC   = 0;
    localparam int MF_REG  = 1;
    localparam int MF_MEM  = 2;
    localparam int MF_HALT = 3;

endpackage

// File: rtl/ctc_fifo.sv
// Synchronous FIFO of expected commit records; one push and one pop per cycle, registered full/empty.
// Latency: a record is readable at the head one cycle after its push. Push ignored when full, pop ignored when empty.
module ctc_fifo
    import ctc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  ctc_rec_t push_dat,
    input  logic     pop,
    output ctc_rec_t pop_dat,
    output logic     full,
    output logic     empty
);
    localparam int PTR_W = $clog2(DEPTH);

    ctc_rec_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/commit_trace_checker.sv
// Compares each retirement against the oldest buffered golden record; CTC_PC_CHECK_EN enables PC compare.
// Results registered one cycle after cm_valid; never stalls the core, exp_ready drops when full or not RUN.
module commit_trace_checker
    import ctc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exp_valid,
    output logic             exp_ready,
    input  logic [15:0]      exp_pc,
    input  logic [15:0]      exp_wdata,
    input  logic [15:0]      exp_maddr,
    input  logic [15:0]      exp_mdata,
    input  logic             exp_regwr,
    input  logic             exp_memwr,
    input  logic             exp_halt,
    input  logic [2:0]       exp_wreg,
    input  logic             cm_valid,
    input  logic [15:0]      cm_pc,
    input  logic [15:0]      cm_wdata,
    input  logic [15:0]      cm_maddr,
    input  logic [15:0]      cm_mdata,
    input  logic             cm_regwr,
    input  logic             cm_memwr,
    input  logic             cm_halt,
    input  logic [2:0]       cm_wreg,
    output logic [CNT_W-1:0] inst_count,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_inum,
    output logic [3:0]       mismatch_field,
    output logic             done
);
    ctc_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] inum_q, inum_d;
    logic [3:0]       field_q, field_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;

    ctc_rec_t push_rec, head;
    logic     fifo_full, fifo_empty, push, pop;
    logic [3:0] cmp;

    assign exp_ready = ~fifo_full & (state_q == RUN);
    assign push      = exp_valid & exp_ready;
    assign pop       = cm_valid & (state_q == RUN) & ~fifo_empty;

    always_comb begin
        push_rec       = '0;
`ifdef CTC_PC_CHECK_EN
        push_rec.pc    = exp_pc;
`endif
        push_rec.regwr = exp_regwr;
        push_rec.wreg  = exp_wreg;
        push_rec.wdata = exp_wdata;
        push_rec.memwr = exp_memwr;
        push_rec.maddr = exp_maddr;
        push_rec.mdata = exp_mdata;
        push_rec.halt  = exp_halt;
    end

`ifndef CTC_PC_CHECK_EN
    logic unused_pc;
    assign unused_pc = ^{exp_pc, cm_pc};
`endif

    ctc_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_rec),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Write data / store payload only matter when the record says the write happens.
    always_comb begin
        cmp = '0;
`ifdef CTC_PC_CHECK_EN
        cmp[MF_PC]   = (cm_pc != head.pc);
`endif
        cmp[MF_REG]  = (cm_regwr != head.regwr) |
                       (head.regwr & ((cm_wreg != head.wreg) | (cm_wdata != head.wdata)));
        cmp[MF_MEM]  = (cm_memwr != head.memwr) |
                       (head.memwr & ((cm_maddr != head.maddr) | (cm_mdata != head.mdata)));
        cmp[MF_HALT] = (cm_halt != head.halt);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        inum_d     = inum_q;
        field_d    = field_q;
        mismatch_d = mismatch_q;
        done_d     = done_q;
        if (state_q == RUN && cm_valid) begin
            if (fifo_empty) begin
                mismatch_d       = 1'b1;
                field_d          = '0;
                field_d[MF_HALT] = 1'b1;
                inum_d           = count_q;
                state_d          = FAIL;
            end else if (|cmp) begin
                mismatch_d = 1'b1;
                field_d    = cmp;
                inum_d     = count_q;
                state_d    = FAIL;
            end else begin
                count_d = count_q + CNT_W'(1);
                if (head.halt) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            count_q    <= '0;
            inum_q     <= '0;
            field_q    <= '0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            inum_q     <= inum_d;
            field_q    <= field_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    assign inst_count     = count_q;
    assign mismatch       = mismatch_q;
    assign mismatch_inum  = inum_q;
    assign mismatch_field = field_q;
    assign done           = done_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Directed bench for commit_trace_checker (DEPTH=4, CNT_W=16); PC expectations follow CTC_PC_CHECK_EN.
module tb_commit_trace_checker;
    logic        clk = 1'b0;
    logic        rst;
    logic        exp_valid, exp_ready;
    logic [15:0] exp_pc, exp_wdata, exp_maddr, exp_mdata;
    logic        exp_regwr, exp_memwr, exp_halt;
    logic [2:0]  exp_wreg;
    logic        cm_valid;
    logic [15:0] cm_pc, cm_wdata, cm_maddr, cm_mdata;
    logic        cm_regwr, cm_memwr, cm_halt;
    logic [2:0]  cm_wreg;
    logic [15:0] inst_count, mismatch_inum;
    logic        mismatch, done;
    logic [3:0]  mismatch_field;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    commit_trace_checker #(.DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_pc(exp_pc), .exp_wdata(exp_wdata), .exp_maddr(exp_maddr), .exp_mdata(exp_mdata),
        .exp_regwr(exp_regwr), .exp_memwr(exp_memwr), .exp_halt(exp_halt), .exp_wreg(exp_wreg),
        .cm_valid(cm_valid),
        .cm_pc(cm_pc), .cm_wdata(cm_wdata), .cm_maddr(cm_maddr), .cm_mdata(cm_mdata),
        .cm_regwr(cm_regwr), .cm_memwr(cm_memwr), .cm_halt(cm_halt), .cm_wreg(cm_wreg),
        .inst_count(inst_count), .mismatch(mismatch), .mismatch_inum(mismatch_inum),
        .mismatch_field(mismatch_field), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_exp(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                           input logic [15:0] wd, input logic mw, input logic [15:0] ma,
                           input logic [15:0] md, input logic h);
        exp_pc = pc; exp_regwr = rw; exp_wreg = wr; exp_wdata = wd;
        exp_memwr = mw; exp_maddr = ma; exp_mdata = md; exp_halt = h;
    endtask

    task automatic set_cm(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                          input logic [15:0] wd, input logic mw, input logic [15:0] ma,
                          input logic [15:0] md, input logic h);
        cm_pc = pc; cm_regwr = rw; cm_wreg = wr; cm_wdata = wd;
        cm_memwr = mw; cm_maddr = ma; cm_mdata = md; cm_halt = h;
    endtask

    task automatic push(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                        input logic [15:0] wd, input logic mw, input logic [15:0] ma,
                        input logic [15:0] md, input logic h);
        set_exp(pc, rw, wr, wd, mw, ma, md, h);
        exp_valid = 1'b1;
        tick();
        exp_valid = 1'b0;
    endtask

    task automatic retire(input logic [15:0] pc, input logic rw, input logic [2:0] wr,
                          input logic [15:0] wd, input logic mw, input logic [15:0] ma,
                          input logic [15:0] md, input logic h);
        set_cm(pc, rw, wr, wd, mw, ma, md, h);
        cm_valid = 1'b1;
        tick();
        cm_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        cm_valid  = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        total++; if (exp_ready !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b want=1", tag, exp_ready); end
        total++; if (inst_count !== 16'd0) begin bad++; $display("FAIL %s_count got=%0d want=0", tag, inst_count); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL %s_mismatch got=%b want=0", tag, mismatch); end
        total++; if (mismatch_inum !== 16'd0) begin bad++; $display("FAIL %s_inum got=%0d want=0", tag, mismatch_inum); end
        total++; if (mismatch_field !== 4'b0000) begin bad++; $display("FAIL %s_field got=%b want=0000", tag, mismatch_field); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done got=%b want=0", tag, done); end
    endtask

    task automatic test_reset();
        set_exp(16'h0, 0, 3'd0, 16'h0, 0, 16'h0, 16'h0, 0);
        set_cm(16'h0, 0, 3'd0, 16'h0, 0, 16'h0, 16'h0, 0);
        do_reset();
        check_idle("reset");
    endtask

    task automatic test_basic();
        do_reset();
        push(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        push(16'h0002, 0, 3'd0, 16'h0000, 1, 16'h0010, 16'h00AA, 0);
        push(16'h0004, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        retire(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL basic_count1 got=%0d want=1", inst_count); end
        retire(16'h0002, 0, 3'd0, 16'h0000, 1, 16'h0010, 16'h00AA, 0);
        retire(16'h0004, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        total++; if (inst_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d want=3", inst_count); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL basic_done got=%b want=1", done); end
        total++; if (mismatch !== 1'b0) begin bad++; $display("FAIL basic_mismatch got=%b want=0", mismatch); end
        total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL basic_ready_done got=%b want=0", exp_ready); end
        retire(16'h0006, 1, 3'd2, 16'h1234, 0, 16'h0000, 16'h0000, 0);
        total++; if (inst_count !== 16'd3 || mismatch !== 1'b0) begin bad++;
            $display("FAIL done_hold got=count %0d mism %b want=count 3 mism 0", inst_count, mismatch); end
    endtask

    task automatic test_reg_mismatch();
        do_reset();
        push(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        push(16'h0002, 1, 3'd2, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0002, 1, 3'd2, 16'h0006, 0, 16'h0000, 16'h0000, 0);
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL reg_mismatch got=%b want=1", mismatch); end
        total++; if (mismatch_field !== 4'b0010) begin bad++; $display("FAIL reg_field got=%b want=0010", mismatch_field); end
        total++; if (mismatch_inum !== 16'd1) begin bad++; $display("FAIL reg_inum got=%0d want=1", mismatch_inum); end
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL reg_count got=%0d want=1", inst_count); end
        total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL reg_ready got=%b want=0", exp_ready); end
    endtask

    task automatic test_mem_and_dontcare();
        do_reset();
        // regwr=0 on both sides: differing wreg/wdata must be ignored
        push(16'h0000, 0, 3'd3, 16'h1111, 0, 16'h0000, 16'h0000, 0);
        push(16'h0002, 0, 3'd0, 16'h0000, 1, 16'h0010, 16'h00AA, 0);
        retire(16'h0000, 0, 3'd5, 16'h2222, 0, 16'h0000, 16'h0000, 0);
        total++; if (inst_count !== 16'd1 || mismatch !== 1'b0) begin bad++;
            $display("FAIL dontcare got=count %0d mism %b want=count 1 mism 0", inst_count, mismatch); end
        retire(16'h0002, 0, 3'd0, 16'h0000, 1, 16'h0010, 16'h00AB, 0);
        total++; if (mismatch_field !== 4'b0100) begin bad++; $display("FAIL mem_field got=%b want=0100", mismatch_field); end
        total++; if (mismatch_inum !== 16'd1) begin bad++; $display("FAIL mem_inum got=%0d want=1", mismatch_inum); end
        do_reset();
        push(16'h0000, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0000, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        total++; if (mismatch_field !== 4'b1000 || done !== 1'b0) begin bad++;
            $display("FAIL halt_field got=%b done %b want=1000 done 0", mismatch_field, done); end
    endtask

    task automatic test_underflow();
        do_reset();
        retire(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        total++; if (mismatch_field !== 4'b1000) begin bad++; $display("FAIL uf_field got=%b want=1000", mismatch_field); end
        total++; if (mismatch_inum !== 16'd0) begin bad++; $display("FAIL uf_inum got=%0d want=0", mismatch_inum); end
        total++; if (mismatch !== 1'b1) begin bad++; $display("FAIL uf_mismatch got=%b want=1", mismatch); end
        total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL uf_ready got=%b want=0", exp_ready); end
        // push and retire in the same cycle on an empty FIFO is still an underflow
        do_reset();
        set_exp(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        set_cm(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        exp_valid = 1'b1; cm_valid = 1'b1;
        tick();
        exp_valid = 1'b0; cm_valid = 1'b0;
        total++; if (mismatch !== 1'b1 || mismatch_field !== 4'b1000) begin bad++;
            $display("FAIL uf_same_cycle got=mism %b field %b want=mism 1 field 1000", mismatch, mismatch_field); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++)
            push(16'(2*i), 1, 3'(i), 16'(16'h0100 + i), 0, 16'h0000, 16'h0000, 0);
        total++; if (exp_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", exp_ready); end
        // fifth offer matches the extra retirement below, so acceptance would hide the underflow
        set_exp(16'h0020, 1, 3'd7, 16'h0777, 0, 16'h0000, 16'h0000, 0);
        set_cm(16'h0000, 1, 3'd0, 16'h0100, 0, 16'h0000, 16'h0000, 0);
        exp_valid = 1'b1; cm_valid = 1'b1;
        tick();
        exp_valid = 1'b0; cm_valid = 1'b0;
        total++; if (exp_ready !== 1'b1) begin bad++; $display("FAIL full_ready_after_pop got=%b want=1", exp_ready); end
        for (int i = 1; i < 4; i++)
            retire(16'(2*i), 1, 3'(i), 16'(16'h0100 + i), 0, 16'h0000, 16'h0000, 0);
        total++; if (inst_count !== 16'd4 || mismatch !== 1'b0) begin bad++;
            $display("FAIL full_drain got=count %0d mism %b want=count 4 mism 0", inst_count, mismatch); end
        retire(16'h0020, 1, 3'd7, 16'h0777, 0, 16'h0000, 16'h0000, 0);
        total++; if (mismatch_field !== 4'b1000 || mismatch_inum !== 16'd4) begin bad++;
            $display("FAIL full_refused got=field %b inum %0d want=field 1000 inum 4", mismatch_field, mismatch_inum); end
    endtask

    task automatic test_pc();
        do_reset();
        push(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0002, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
`ifdef CTC_PC_CHECK_EN
        total++; if (mismatch_field !== 4'b0001 || inst_count !== 16'd0) begin bad++;
            $display("FAIL pc_check got=field %b count %0d want=field 0001 count 0", mismatch_field, inst_count); end
`else
        total++; if (mismatch !== 1'b0 || inst_count !== 16'd1) begin bad++;
            $display("FAIL pc_ignored got=mism %b count %0d want=mism 0 count 1", mismatch, inst_count); end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        push(16'h0002, 1, 3'd2, 16'h0009, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0000, 1, 3'd1, 16'h0005, 0, 16'h0000, 16'h0000, 0);
        total++; if (inst_count !== 16'd1) begin bad++; $display("FAIL mid_pre got=%0d want=1", inst_count); end
        do_reset();
        check_idle("mid_reset");
        // stale record (wdata 0x0009) must be gone, or this first retirement would mismatch
        push(16'h0000, 1, 3'd3, 16'h0042, 0, 16'h0000, 16'h0000, 0);
        push(16'h0002, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        retire(16'h0000, 1, 3'd3, 16'h0042, 0, 16'h0000, 16'h0000, 0);
        retire(16'h0002, 0, 3'd0, 16'h0000, 0, 16'h0000, 16'h0000, 1);
        total++; if (inst_count !== 16'd2 || done !== 1'b1 || mismatch !== 1'b0) begin bad++;
            $display("FAIL mid_fresh got=count %0d done %b mism %b want=count 2 done 1 mism 0",
                     inst_count, done, mismatch); end
    endtask

    initial begin
        rst = 1'b0;
        exp_valid = 1'b0;
        cm_valid  = 1'b0;
        test_reset();
        test_basic();
        test_reg_mismatch();
        test_mem_and_dontcare();
        test_underflow();
        test_full();
        test_pc();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Synthesizable in-system checker for the processor's retirement stream. It buffers expected commit records supplied by a golden model over a valid/ready stream. Each time the processor retires an instruction, the oldest buffered record is compared field by field against that retirement. Results are a retired-instruction count, a sticky mismatch report, and a done flag. It sits beside the processor core and taps the commit point that the trace monitor records: register write, memory write and halt.

## Interface
Parameters:
- `DEPTH`, 4: expected-record FIFO entries; power of two, ≥2.
- `CNT_W`, 16: width of the instruction counter.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is synchronous and active-low.
- `exp_valid`  in  1  expected record offered.
- `exp_ready`  out  1  record accepted on `exp_valid & exp_ready`.
- `exp_pc`, `exp_wdata`, `exp_maddr`, `exp_mdata`  in  16 each  expected PC, register write data, memory address, store data.
- `exp_regwr`, `exp_memwr`, `exp_halt`  in  1 each  expected event flags.
- `exp_wreg`  in  3  expected destination register.
- `cm_valid`  in  1  one instruction retires this cycle.
- `cm_pc`, `cm_wdata`, `cm_maddr`, `cm_mdata`  in  16 each  retired values.
- `cm_regwr`, `cm_memwr`, `cm_halt`  in  1 each  retired event flags.
- `cm_wreg`  in  3  retired destination register.
- `inst_count`  out  CNT_W  matched retirements.
- `mismatch`  out  1  sticky failure.
- `mismatch_inum`  out  CNT_W  value of `inst_count` at the failing retirement.
- `mismatch_field`  out  4  failure cause: [0] PC, [1] register, [2] memory, [3] halt or underflow.
- `done`  out  1  a halt retirement matched.

## Operation
- FSM states: RUN (reset state), DONE, FAIL.
- `exp_ready = !full & (state==RUN)`. A push writes the record at the write pointer.
- Retirement in RUN (`cm_valid=1`):
  - FIFO empty → underflow: set `mismatch_field=4'b1000`, go to FAIL.
  - Otherwise pop the head record and compare it:
    - PC bit: `cm_pc != exp_pc`. Only when `CTC_PC_CHECK_EN` is defined.
    - Register bit: `cm_regwr != exp_regwr`, or, when `exp_regwr=1`, a mismatch in `wreg` or `wdata`.
    - Memory bit: `cm_memwr != exp_memwr`, or, when `exp_memwr=1`, a mismatch in `maddr` or `mdata`.
    - Halt bit: `cm_halt != exp_halt`.
- Result of a compare:
  - Any bit set → latch `mismatch=1`, `mismatch_field`, and `mismatch_inum=inst_count`; go to FAIL.
  - All clear → `inst_count` increments (wraps modulo 2^CNT_W). If `exp_halt=1`, go to DONE with `done=1`.
- DONE and FAIL are terminal until reset: `exp_ready=0`, `cm_valid` ignored, all outputs hold.
- Push and pop in the same cycle:
  - Both occur, and occupancy is unchanged.
  - A record pushed this cycle is not visible to a same-cycle retirement. Empty + push + retire → underflow.
- Pointers are log2(DEPTH) bits. The occupancy counter is log2(DEPTH)+1 bits and wraps cleanly.
- Reset mid-stream discards FIFO contents and returns to RUN.

## Timing
- Reset values: `exp_ready=1` (RUN, empty FIFO), `inst_count=0`, `mismatch=0`, `mismatch_inum=0`, `mismatch_field=0`, `done=0`.
- All outputs are registered. Compare results appear the cycle after the `cm_valid` edge.
- `exp_ready` is combinational from registered state, so a full FIFO refuses a push even when a pop occurs in the same cycle.
- One retirement is processed per cycle with no stall. The checker never back-pressures the core.
- FIFO write-to-read latency: a record is poppable one cycle after its push.

## Configuration
- `CTC_PC_CHECK_EN` defined: PC is compared and can set `mismatch_field[0]`.
- Not defined: PC is neither stored nor compared. `exp_pc`/`cm_pc` are unused, `mismatch_field[0]` stays 0, and FIFO width drops by 16 bits.

## Structure
- Shared package `ctc_pkg`:
  - packed struct `ctc_rec_t` holding the record fields;
  - enum `ctc_state_e` {RUN, DONE, FAIL};
  - localparams for the `mismatch_field` bit indices.
- One sub-module, `ctc_fifo`: a synchronous FIFO of `ctc_rec_t` parameterized by DEPTH, with full/empty and one push plus one pop per cycle. The FSM and comparator live in the top module.

## Test plan
- Three records are pushed (regwr r1=0x0005 at PC 0x0000, a store to 0x0010 of 0x00AA, halt at PC 0x0004), followed by three identical retirements → `inst_count=3`, `done=1`, `mismatch=0`.
- Second retirement carries `cm_wdata=0x0006` against expected 0x0005 → `mismatch=1`, `mismatch_field=4'b0010`, `mismatch_inum=1`, `inst_count` frozen at 1.
- Retirement with an empty FIFO → `mismatch_field=4'b1000`, `mismatch_inum=0`, state FAIL, `exp_ready=0`.
- Four pushes with DEPTH=4 → `exp_ready=0`. A retirement plus a fifth offer in the same cycle → fifth refused, occupancy 3, `exp_ready=1` the next cycle.
- Wrong PC (0x0002 vs 0x0000):
  - with `CTC_PC_CHECK_EN` defined → `mismatch_field=4'b0001`;
  - without it → match, `inst_count=1`.
- Reset asserted after two pushes and one match → all outputs return to reset values and a fresh sequence passes.
